// File: rtl/udivider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udivider_pkg
// Description : Shared state encoding and default sizing for the unsigned
//               divider and its execute-stage neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package udivider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/udivider_step.sv
`default_nettype none
// ============================================================================
// Module      : udivider_step
// Description : One combinational restoring shift-subtract step.
// Revision    : 1.0 - initial release
// ============================================================================
module udivider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_diff;
    logic           w_borrow;

    // One extra bit above the WIDTH+1 difference captures the borrow cleanly.
    assign {w_borrow, w_diff} = {1'b0, i_rem, i_bit} - {2'b00, i_div};

    assign o_qbit = ~w_borrow;
    assign o_rem  = w_borrow ? {i_rem[WIDTH-2:0], i_bit} : w_diff[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/udivider.sv
`default_nettype none
// ============================================================================
// Module      : udivider
// Description : Sequential unsigned divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module udivider
    import udivider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH-1:0] w_rem_next;
    logic             w_qbit;

    udivider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_q[WIDTH-1]),
        .i_div  (r_div),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_div       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // Requests arriving while busy are deliberately dropped.
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state     <= S_FIN;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_div_zero  <= 1'b0;
                        r_quotient  <= {r_q[WIDTH-2:0], w_qbit};
                        r_remainder <= w_rem_next;
                    end
                end
                S_IDLE, S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        if (in2 == '0) begin
                            r_state     <= S_FIN;
                            r_done      <= 1'b1;
                            r_div_zero  <= 1'b1;
                            r_quotient  <= '1;
                            r_remainder <= in1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_rem   <= '0;
                            r_q     <= in1;
                            r_div   <= in2;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule
`default_nettype wire

// File: tb/tb_udivider.sv
`default_nettype none
// ============================================================================
// Module      : tb_udivider
// Description : Scoreboard bench for udivider with a reference division model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udivider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           issue;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    udivider #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_and_done", 64'(busy & done), 64'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", 64'(quotient), 64'(e.q));
                    check("remainder", 64'(remainder), 64'(e.r));
                    check("div_zero", 64'(div_zero), 64'(e.dz));
                    check("latency", 64'(cyc - e.issue), 64'(e.lat));
                end
            end
        end
    end

    // Drive one request at a negedge; optionally register its expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        in1   = a;
        in2   = b;
        start = 1'b1;
        if (push) begin
            e.q     = (b == 0) ? '1 : a / b;
            e.r     = (b == 0) ? a  : a % b;
            e.dz    = (b == 0);
            e.lat   = (b == 0) ? 1 : W + 1;
            e.issue = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (push) check("busy_after_start", 64'(busy), 64'(b != 0));
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [W-1:0] edges [3];
        edges[0] = '0;
        edges[1] = 32'd1;
        edges[2] = '1;
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd100, 32'd7, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_idle();
        issue(32'd5, 32'd9, 1'b1);
        wait_idle();
        issue(32'h1234_5678, 32'd0, 1'b1);
        wait_idle();

        // Second request during busy must be ignored.
        issue(32'd1000, 32'd10, 1'b1);
        repeat (4) @(negedge clk);
        issue(32'd9, 32'd3, 1'b0);
        wait_idle();

        // Issued in the FIN cycle of the previous operation.
        issue(32'h8000_0000, 32'h0001_0000, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("q_hold_idle", 64'(quotient), 64'h8000);
        issue(32'd7, 32'd2, 1'b1);
        check("q_hold_busy", 64'(quotient), 64'h8000);
        check("r_hold_busy", 64'(remainder), 64'h0);
        wait_idle();

        // Reset mid-operation aborts with no done.
        @(negedge clk);
        issue(32'd500, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_q", 64'(quotient), 64'd0);
        check("abort_r", 64'(remainder), 64'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                issue(edges[i], edges[j], 1'b1);
                wait_idle();
                @(negedge clk);
            end
        end

        for (int k = 0; k < 200; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            issue(a, b, 1'b1);
            wait_idle();
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
